// File: rtl/interrupt_controller.sv
// Interrupt controller: rising-edge latched pending bits, software mask, fixed
// lowest-index-first priority, one request to the CPU with ack/EOI handshake.
module interrupt_controller #(
  parameter int SOURCES = 8,
  parameter int DATA_BITS = 32,
  localparam int VECTOR_BITS = $clog2(SOURCES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SOURCES-1:0]     sources,
  output logic [SOURCES-1:0]     source_clear,
  input  logic [1:0]             address,
  input  logic [DATA_BITS-1:0]   data_in,
  input  logic                   nwr,
  output logic [DATA_BITS-1:0]   data_out,
  output logic                   irq,
  input  logic                   irq_ack,
  output logic [VECTOR_BITS-1:0] irq_vector
);

  localparam int RD_W = (DATA_BITS > 18) ? DATA_BITS : 18;

  typedef enum logic [1:0] {IDLE, REQUEST, IN_SERVICE} state_t;

  state_t                 state, state_nxt;
  logic [SOURCES-1:0]     pending, mask, src_prev;
  logic [SOURCES-1:0]     active, rise, w1c, ack_clr, clr_nxt;
  logic [VECTOR_BITS-1:0] winner, vec_nxt;
  logic                   irq_nxt, any_active, ack_fire, eoi_wr;
  logic [RD_W-1:0]        rd;

  function automatic logic [VECTOR_BITS-1:0] lowest_set(input logic [SOURCES-1:0] v);
    lowest_set = '0;
    for (int i = SOURCES - 1; i >= 0; i--)
      if (v[i]) lowest_set = VECTOR_BITS'(i);
  endfunction

  assign active     = pending & mask;
  assign any_active = |active;
  assign winner     = lowest_set(active);
  assign rise       = sources & ~src_prev;
  assign ack_fire   = (state == REQUEST) && any_active && irq_ack;
  assign eoi_wr     = !nwr && (address == 2'd3);
  assign w1c        = (!nwr && (address == 2'd0)) ? data_in[SOURCES-1:0] : '0;
  assign ack_clr    = ack_fire ? (SOURCES'(1) << irq_vector) : '0;

  // A new edge on the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      src_prev <= '0;
    end else begin
      src_prev <= sources;
      pending  <= (pending & ~(w1c | ack_clr)) | rise;
      if (!nwr && (address == 2'd1))
        mask <= data_in[SOURCES-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      irq          <= 1'b0;
      irq_vector   <= '0;
      source_clear <= '0;
    end else begin
      state        <= state_nxt;
      irq          <= irq_nxt;
      irq_vector   <= vec_nxt;
      source_clear <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (any_active) state_nxt = REQUEST;
      REQUEST:    if (!any_active) state_nxt = IDLE;
                  else if (irq_ack) state_nxt = IN_SERVICE;
      IN_SERVICE: if (eoi_wr) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Vector tracks the winner while requesting so a higher priority arrival preempts.
  always_comb begin
    irq_nxt = irq;
    vec_nxt = irq_vector;
    clr_nxt = '0;
    case (state)
      IDLE: if (any_active) begin
        irq_nxt = 1'b1;
        vec_nxt = winner;
      end
      REQUEST: begin
        if (!any_active) irq_nxt = 1'b0;
        else if (irq_ack) begin
          irq_nxt = 1'b0;
          clr_nxt = ack_clr;
        end else vec_nxt = winner;
      end
      default: irq_nxt = 1'b0;
    endcase
  end

  always_comb begin
    rd = '0;
    case (address)
      2'd0: rd[SOURCES-1:0] = pending;
      2'd1: rd[SOURCES-1:0] = mask;
      2'd2: begin
        rd[VECTOR_BITS-1:0] = irq_vector;
        rd[16]              = irq;
        rd[17]              = (state == IN_SERVICE);
      end
      default: rd = '0;
    endcase
  end

  assign data_out = rd[DATA_BITS-1:0];

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; expectations are queued as stimulus
// is applied and popped against DUT outputs.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sources;
  logic [7:0]  source_clear;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic        nwr;
  logic [31:0] data_out;
  logic        irq;
  logic        irq_ack;
  logic [2:0]  irq_vector;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  interrupt_controller #(.SOURCES(8), .DATA_BITS(32)) dut (
    .clk(clk), .reset(reset), .sources(sources), .source_clear(source_clear),
    .address(address), .data_in(data_in), .nwr(nwr), .data_out(data_out),
    .irq(irq), .irq_ack(irq_ack), .irq_vector(irq_vector)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    nwr     = 1'b0;
    tick();
    nwr     = 1'b1;
  endtask

  task automatic rd_obs(input logic [1:0] a);
    address = a;
    #1;
    observe(data_out);
  endtask

  initial begin
    reset = 1'b1; sources = '0; address = '0; data_in = '0; nwr = 1'b1; irq_ack = 1'b0;
    tick();
    expect_v("reset_irq", 32'h0);
    expect_v("reset_vector", 32'h0);
    expect_v("reset_clear", 32'h0);
    expect_v("reset_pending", 32'h0);
    expect_v("reset_mask", 32'h0);
    observe(32'(irq));
    observe(32'(irq_vector));
    observe(32'(source_clear));
    rd_obs(2'd0);
    rd_obs(2'd1);
    reset = 1'b0;
    tick();

    // 1: single source, mask bit 0
    wr(2'd1, 32'h01);
    expect_v("t1_mask_rb", 32'h01);
    rd_obs(2'd1);
    sources = 8'h01;
    tick();
    expect_v("t1_pending", 32'h01);
    expect_v("t1_irq_e1", 32'h0);
    rd_obs(2'd0);
    observe(32'(irq));
    tick();
    expect_v("t1_irq_e2", 32'h1);
    expect_v("t1_vector", 32'h0);
    observe(32'(irq));
    observe(32'(irq_vector));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    sources = 8'h00;
    expect_v("t1_clear", 32'h01);
    observe(32'(source_clear));
    tick();
    wr(2'd3, 32'h0);
    expect_v("t1_status_idle", 32'h0);
    rd_obs(2'd2);

    // 2: two simultaneous sources, ack and EOI
    wr(2'd1, 32'hFF);
    sources = 8'h28;
    tick();
    tick();
    expect_v("t2_irq", 32'h1);
    expect_v("t2_vector", 32'h3);
    observe(32'(irq));
    observe(32'(irq_vector));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    expect_v("t2_clear", 32'h08);
    expect_v("t2_pending", 32'h20);
    expect_v("t2_irq_low", 32'h0);
    observe(32'(source_clear));
    rd_obs(2'd0);
    observe(32'(irq));
    sources = 8'h20;
    tick();
    expect_v("t2_clear_one_cycle", 32'h0);
    expect_v("t2_status_insvc", 32'h0002_0003);
    observe(32'(source_clear));
    rd_obs(2'd2);
    wr(2'd3, 32'h0);
    expect_v("t2_irq_after_eoi1", 32'h0);
    observe(32'(irq));
    tick();
    expect_v("t2_irq_reassert", 32'h1);
    expect_v("t2_vector5", 32'h5);
    observe(32'(irq));
    observe(32'(irq_vector));

    // 4: higher priority arrival preempts while requesting vector 5
    sources = 8'h22;
    tick();
    expect_v("t4_vector_hold", 32'h5);
    observe(32'(irq_vector));
    tick();
    expect_v("t4_vector_preempt", 32'h1);
    expect_v("t4_irq_stays", 32'h1);
    observe(32'(irq_vector));
    observe(32'(irq));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    expect_v("t4_clear", 32'h02);
    observe(32'(source_clear));
    sources = 8'h20;
    wr(2'd0, 32'h20);
    sources = 8'h00;
    wr(2'd3, 32'h0);
    tick();

    // 5a: ack while idle is ignored
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    expect_v("t5_idle_ack_clear", 32'h0);
    expect_v("t5_idle_ack_status", 32'h0);
    observe(32'(source_clear));
    address = 2'd2;
    #1;
    observe(data_out & 32'h0003_0000);

    // 3: masked source, unmask, W1C
    wr(2'd1, 32'h00);
    sources = 8'h04;
    tick();
    tick();
    expect_v("t3_pending_masked", 32'h04);
    expect_v("t3_irq_masked", 32'h0);
    rd_obs(2'd0);
    observe(32'(irq));
    wr(2'd1, 32'h04);
    tick();
    expect_v("t3_irq_unmasked", 32'h1);
    expect_v("t3_vector", 32'h2);
    observe(32'(irq));
    observe(32'(irq_vector));
    // 5b: EOI while requesting is ignored
    wr(2'd3, 32'h0);
    expect_v("t5_eoi_req_clear", 32'h0);
    expect_v("t5_eoi_req_status", 32'h0001_0002);
    observe(32'(source_clear));
    rd_obs(2'd2);
    wr(2'd0, 32'h04);
    tick();
    expect_v("t3_irq_w1c", 32'h0);
    expect_v("t3_insvc", 32'h0);
    expect_v("t3_pending_w1c", 32'h0);
    observe(32'(irq));
    address = 2'd2;
    #1;
    observe(data_out & 32'h0002_0000);
    rd_obs(2'd0);

    // 6: asynchronous reset during in-service
    sources = 8'h00;
    wr(2'd1, 32'hFF);
    sources = 8'h40;
    tick();
    tick();
    sources = 8'hC0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    expect_v("t6_pre_clear", 32'h40);
    expect_v("t6_pre_pending", 32'h80);
    observe(32'(source_clear));
    rd_obs(2'd0);
    #1;
    reset = 1'b1;
    #1;
    expect_v("t6_rst_irq", 32'h0);
    expect_v("t6_rst_clear", 32'h0);
    expect_v("t6_rst_pending", 32'h0);
    expect_v("t6_rst_mask", 32'h0);
    observe(32'(irq));
    observe(32'(source_clear));
    rd_obs(2'd0);
    rd_obs(2'd1);
    tick();
    reset = 1'b0;
    tick();
    expect_v("t6_release_pending", 32'hC0);
    expect_v("t6_release_status", 32'h0);
    rd_obs(2'd0);
    rd_obs(2'd2);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
